// File: rtl/oc_pkg.sv
// rtl/oc_pkg.sv - operand collector shared sizes, entry-state encoding and bank tag field offsets
package oc_pkg;

   localparam int NUM_OC        = 8;
   localparam int NUM_BANK      = 4;
   localparam int OCID_W        = $clog2(NUM_OC);
   localparam int BANK_W        = $clog2(NUM_BANK);

   // Per-bank slice of bank_ocid is {rd_valid, ocid}.
   localparam int TAG_W         = 1 + OCID_W;
   localparam int TAG_OCID_LSB  = 0;
   localparam int TAG_VALID_BIT = OCID_W;

   typedef enum logic [1:0] {
      OC_FREE    = 2'd0,
      OC_COLLECT = 2'd1,
      OC_READY   = 2'd2
   } oc_state_e;

endpackage

// File: rtl/oc_rr_arbiter.sv
// rtl/oc_rr_arbiter.sv - round-robin pick over N requests; pointer moves past the winner on advance
module oc_rr_arbiter #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int i = 0; i < N; i++) begin
         cand = IDX_W'((int'(ptr) + i) % N);
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
      grant[grant_idx] = grant_valid;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (advance && grant_valid) begin
         ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/operand_collector_unit.sv
// rtl/operand_collector_unit.sv - collector entries filled from register-file bank returns, dispatched round-robin
import oc_pkg::*;

module operand_collector_unit #(
   parameter int DATA_W  = 256,
   parameter int WARP_W  = 3,
   parameter int INSTR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   output logic [OCID_W-1:0]          alloc_ocid,
   input  logic [WARP_W-1:0]          alloc_warp,
   input  logic [INSTR_W-1:0]         alloc_instr,
   input  logic                       alloc_src1_need,
   input  logic                       alloc_src2_need,
   input  logic [BANK_W-1:0]          alloc_src1_bank,
   input  logic [BANK_W-1:0]          alloc_src2_bank,
   input  logic [NUM_BANK*TAG_W-1:0]  bank_ocid,
   input  logic [NUM_BANK-1:0]        bank_same,
   input  logic [NUM_BANK*DATA_W-1:0] bank_rd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OCID_W-1:0]          out_ocid,
   output logic [WARP_W-1:0]          out_warp,
   output logic [INSTR_W-1:0]         out_instr,
   output logic [DATA_W-1:0]          out_src1,
   output logic [DATA_W-1:0]          out_src2,
   output logic                       protocol_err
);

   oc_state_e           state [NUM_OC];
   logic [NUM_OC-1:0]   need1, need2, fill1, fill2;
   logic [BANK_W-1:0]   bank1 [NUM_OC];
   logic [BANK_W-1:0]   bank2 [NUM_OC];
   logic [WARP_W-1:0]   e_warp [NUM_OC];
   logic [INSTR_W-1:0]  e_instr [NUM_OC];
   logic [DATA_W-1:0]   e_src1 [NUM_OC];
   logic [DATA_W-1:0]   e_src2 [NUM_OC];

   logic [NUM_BANK-1:0] tag_valid, tag_same;
   logic [OCID_W-1:0]   tag_ocid [NUM_BANK];

   logic [NUM_OC-1:0]   fill1_set, fill2_set, done, ready_vec, grant;
   logic [DATA_W-1:0]   src1_wdata [NUM_OC];
   logic [DATA_W-1:0]   src2_wdata [NUM_OC];
   logic [NUM_BANK-1:0] bank_err;
   logic [DATA_W-1:0]   rdata;
   logic [OCID_W-1:0]   k_idx, grant_idx;
   logic                grant_valid, load, alloc_fire;

   // Lowest-index FREE entry, from registered state only.
   always_comb begin
      alloc_ocid  = '0;
      alloc_ready = 1'b0;
      for (int k = NUM_OC - 1; k >= 0; k--) begin
         if (state[k] == OC_FREE) begin
            alloc_ocid  = OCID_W'(k);
            alloc_ready = 1'b1;
         end
      end
   end

   assign alloc_fire = alloc_valid & alloc_ready;

   // Steer each registered bank tag to a slot of its entry.
   always_comb begin
      bank_err  = '0;
      fill1_set = '0;
      fill2_set = '0;
      rdata     = '0;
      k_idx     = '0;
      for (int k = 0; k < NUM_OC; k++) begin
         src1_wdata[k] = '0;
         src2_wdata[k] = '0;
      end
      for (int b = 0; b < NUM_BANK; b++) begin
         rdata = bank_rd_data[b*DATA_W +: DATA_W];
         k_idx = tag_ocid[b];
         if (tag_valid[b]) begin
            if (state[k_idx] == OC_FREE) begin
               bank_err[b] = 1'b1;
            end else if (tag_same[b]) begin
               fill1_set[k_idx]  = 1'b1;
               fill2_set[k_idx]  = 1'b1;
               src1_wdata[k_idx] = rdata;
               src2_wdata[k_idx] = rdata;
            end else if (need1[k_idx] && !fill1[k_idx] && bank1[k_idx] == BANK_W'(b)) begin
               fill1_set[k_idx]  = 1'b1;
               src1_wdata[k_idx] = rdata;
            end else if (need2[k_idx] && !fill2[k_idx] && bank2[k_idx] == BANK_W'(b)) begin
               fill2_set[k_idx]  = 1'b1;
               src2_wdata[k_idx] = rdata;
            end else begin
               bank_err[b] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_OC; k++) begin
         done[k]      = (!need1[k] | fill1[k] | fill1_set[k]) & (!need2[k] | fill2[k] | fill2_set[k]);
         ready_vec[k] = (state[k] == OC_READY);
      end
   end

   assign load = (!out_valid || out_ready) && grant_valid;

   oc_rr_arbiter #(.N(NUM_OC), .IDX_W(OCID_W)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (ready_vec),
      .advance     (load),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_OC; k++) state[k] <= OC_FREE;
         for (int b = 0; b < NUM_BANK; b++) tag_ocid[b] <= '0;
         need1        <= '0;
         need2        <= '0;
         fill1        <= '0;
         fill2        <= '0;
         tag_valid    <= '0;
         tag_same     <= '0;
         protocol_err <= 1'b0;
         out_valid    <= 1'b0;
         out_ocid     <= '0;
         out_warp     <= '0;
         out_instr    <= '0;
         out_src1     <= '0;
         out_src2     <= '0;
      end else begin
         for (int b = 0; b < NUM_BANK; b++) begin
            tag_valid[b] <= bank_ocid[b*TAG_W + TAG_VALID_BIT];
            tag_ocid[b]  <= bank_ocid[b*TAG_W + TAG_OCID_LSB +: OCID_W];
            tag_same[b]  <= bank_same[b];
         end
         for (int k = 0; k < NUM_OC; k++) begin
            if (alloc_fire && alloc_ocid == OCID_W'(k)) begin
               state[k] <= (alloc_src1_need || alloc_src2_need) ? OC_COLLECT : OC_READY;
               need1[k] <= alloc_src1_need;
               need2[k] <= alloc_src2_need;
               fill1[k] <= 1'b0;
               fill2[k] <= 1'b0;
            end else begin
               if (fill1_set[k]) fill1[k] <= 1'b1;
               if (fill2_set[k]) fill2[k] <= 1'b1;
               if (state[k] == OC_COLLECT && done[k]) state[k] <= OC_READY;
               if (load && grant[k]) state[k] <= OC_FREE;
            end
         end
         protocol_err <= protocol_err | (|bank_err);
         if (load) begin
            out_valid <= 1'b1;
            out_ocid  <= grant_idx;
            out_warp  <= e_warp[grant_idx];
            out_instr <= e_instr[grant_idx];
            out_src1  <= e_src1[grant_idx];
            out_src2  <= e_src2[grant_idx];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Payload needs no reset: every field is rewritten on allocation.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_OC; k++) begin
         if (alloc_fire && alloc_ocid == OCID_W'(k)) begin
            e_warp[k]  <= alloc_warp;
            e_instr[k] <= alloc_instr;
            bank1[k]   <= alloc_src1_bank;
            bank2[k]   <= alloc_src2_bank;
            e_src1[k]  <= '0;
            e_src2[k]  <= '0;
         end else begin
            if (fill1_set[k]) e_src1[k] <= src1_wdata[k];
            if (fill2_set[k]) e_src2[k] <= src2_wdata[k];
         end
      end
   end

endmodule

// File: tb/tb_operand_collector_unit.sv
// tb/tb_operand_collector_unit.sv - scoreboard bench for operand_collector_unit
module tb_operand_collector_unit;
   import oc_pkg::*;

   localparam int DATA_W  = 256;
   localparam int WARP_W  = 3;
   localparam int INSTR_W = 32;

   logic                       clk;
   logic                       rst;
   logic                       alloc_valid;
   logic                       alloc_ready;
   logic [OCID_W-1:0]          alloc_ocid;
   logic [WARP_W-1:0]          alloc_warp;
   logic [INSTR_W-1:0]         alloc_instr;
   logic                       alloc_src1_need, alloc_src2_need;
   logic [BANK_W-1:0]          alloc_src1_bank, alloc_src2_bank;
   logic [NUM_BANK*TAG_W-1:0]  bank_ocid;
   logic [NUM_BANK-1:0]        bank_same;
   logic [NUM_BANK*DATA_W-1:0] bank_rd_data;
   logic                       out_valid, out_ready;
   logic [OCID_W-1:0]          out_ocid;
   logic [WARP_W-1:0]          out_warp;
   logic [INSTR_W-1:0]         out_instr;
   logic [DATA_W-1:0]          out_src1, out_src2;
   logic                       protocol_err;

   operand_collector_unit #(.DATA_W(DATA_W), .WARP_W(WARP_W), .INSTR_W(INSTR_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_valid     (alloc_valid),
      .alloc_ready     (alloc_ready),
      .alloc_ocid      (alloc_ocid),
      .alloc_warp      (alloc_warp),
      .alloc_instr     (alloc_instr),
      .alloc_src1_need (alloc_src1_need),
      .alloc_src2_need (alloc_src2_need),
      .alloc_src1_bank (alloc_src1_bank),
      .alloc_src2_bank (alloc_src2_bank),
      .bank_ocid       (bank_ocid),
      .bank_same       (bank_same),
      .bank_rd_data    (bank_rd_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_ocid        (out_ocid),
      .out_warp        (out_warp),
      .out_instr       (out_instr),
      .out_src1        (out_src1),
      .out_src2        (out_src2),
      .protocol_err    (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [OCID_W-1:0]  ocid;
      logic [WARP_W-1:0]  warp;
      logic [INSTR_W-1:0] instr;
      logic [DATA_W-1:0]  src1;
      logic [DATA_W-1:0]  src2;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic expect_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input int ocid, input int warp, input logic [INSTR_W-1:0] instr,
                               input logic [DATA_W-1:0] s1, input logic [DATA_W-1:0] s2);
      exp_t e;
      e.ocid  = OCID_W'(ocid);
      e.warp  = WARP_W'(warp);
      e.instr = instr;
      e.src1  = s1;
      e.src2  = s2;
      return e;
   endfunction

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            expect_eq("dispatch_expected", DATA_W'(sb.size()), DATA_W'(1));
         end else begin
            exp_t e;
            e = sb.pop_front();
            expect_eq("out_ocid",  DATA_W'(out_ocid),  DATA_W'(e.ocid));
            expect_eq("out_warp",  DATA_W'(out_warp),  DATA_W'(e.warp));
            expect_eq("out_instr", DATA_W'(out_instr), DATA_W'(e.instr));
            expect_eq("out_src1",  out_src1, e.src1);
            expect_eq("out_src2",  out_src2, e.src2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input int warp, input logic [INSTR_W-1:0] instr, input logic n1, input logic n2,
                           input int b1, input int b2, input int exp_ocid);
      alloc_valid     = 1'b1;
      alloc_warp      = WARP_W'(warp);
      alloc_instr     = instr;
      alloc_src1_need = n1;
      alloc_src2_need = n2;
      alloc_src1_bank = BANK_W'(b1);
      alloc_src2_bank = BANK_W'(b2);
      expect_eq("alloc_ready", DATA_W'(alloc_ready), DATA_W'(1));
      expect_eq("alloc_ocid",  DATA_W'(alloc_ocid),  DATA_W'(exp_ocid));
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic set_tag(input int b, input int ocid, input logic same);
      bank_ocid[b*TAG_W +: TAG_W] = {1'b1, OCID_W'(ocid)};
      bank_same[b]                = same;
   endtask

   task automatic clear_tags();
      bank_ocid = '0;
      bank_same = '0;
   endtask

   task automatic set_data(input int b, input logic [DATA_W-1:0] d);
      bank_rd_data[b*DATA_W +: DATA_W] = d;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      expect_eq("drain_left", DATA_W'(sb.size()), DATA_W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [DATA_W-1:0] d0, d1, d2;
      int ord [9];
      ord = '{0, 1, 0, 2, 3, 4, 5, 6, 7};

      rst = 1'b0;
      alloc_valid = 1'b0; alloc_warp = '0; alloc_instr = '0;
      alloc_src1_need = 1'b0; alloc_src2_need = 1'b0;
      alloc_src1_bank = '0; alloc_src2_bank = '0;
      bank_ocid = '0; bank_same = '0; bank_rd_data = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      expect_eq("rst_out_valid",    DATA_W'(out_valid),    DATA_W'(0));
      expect_eq("rst_protocol_err", DATA_W'(protocol_err), DATA_W'(0));
      expect_eq("rst_alloc_ready",  DATA_W'(alloc_ready),  DATA_W'(1));
      expect_eq("rst_alloc_ocid",   DATA_W'(alloc_ocid),   DATA_W'(0));
      expect_eq("rst_out_src1",     out_src1,              DATA_W'(0));
      rst = 1'b1;
      tick();

      // Two banks, two slots; dispatch 4 edges after the first request edge.
      d0 = rnd_data(); d2 = rnd_data();
      sb.push_back(mk(0, 5, 32'h1111_0001, d0, d2));
      do_alloc(5, 32'h1111_0001, 1'b1, 1'b1, 0, 2, 0);
      set_tag(0, 0, 1'b0); tick();
      clear_tags(); set_data(0, d0); tick();
      set_tag(2, 0, 1'b0); tick();
      clear_tags(); set_data(2, d2); tick();
      expect_eq("t1_valid_early", DATA_W'(out_valid), DATA_W'(0));
      tick();
      expect_eq("t1_valid_t4", DATA_W'(out_valid), DATA_W'(1));
      wait_drain(10);

      // Entries 0..2 wait on bank 3 forever; same-bank pair into entry 3.
      for (int i = 0; i < 3; i++) do_alloc(i, 32'h2000 + i, 1'b1, 1'b0, 3, 0, i);
      d0 = rnd_data(); d1 = rnd_data();
      sb.push_back(mk(3, 2, 32'h2222_0003, d0, d1));
      do_alloc(2, 32'h2222_0003, 1'b1, 1'b1, 1, 1, 3);
      set_tag(1, 3, 1'b0); tick();
      set_data(1, d0); tick();
      clear_tags(); set_data(1, d1); tick();
      wait_drain(10);

      // same=1 fills both slots from one read.
      d0 = rnd_data();
      sb.push_back(mk(3, 6, 32'h3333_0003, d0, d0));
      do_alloc(6, 32'h3333_0003, 1'b1, 1'b1, 2, 0, 3);
      set_tag(2, 3, 1'b1); tick();
      clear_tags(); set_data(2, d0); tick();
      wait_drain(10);

      // Only src2 needed: src1 reads back as zero.
      d1 = rnd_data();
      sb.push_back(mk(3, 1, 32'h0000_003b, '0, d1));
      do_alloc(1, 32'h0000_003b, 1'b0, 1'b1, 0, 1, 3);
      set_tag(1, 3, 1'b0); tick();
      clear_tags(); set_data(1, d1); tick();
      wait_drain(10);

      // Two banks fill two slots of one entry in the same cycle.
      d0 = rnd_data(); d1 = rnd_data();
      sb.push_back(mk(3, 7, 32'h0000_003c, d0, d1));
      do_alloc(7, 32'h0000_003c, 1'b1, 1'b1, 0, 1, 3);
      set_tag(0, 3, 1'b0); set_tag(1, 3, 1'b0); tick();
      clear_tags(); set_data(0, d0); set_data(1, d1); tick();
      wait_drain(10);
      expect_eq("t3_no_err", DATA_W'(protocol_err), DATA_W'(0));

      // Reset with 3 COLLECT entries, a held output and an in-flight tag.
      out_ready = 1'b0;
      do_alloc(4, 32'h0000_0066, 1'b0, 1'b0, 0, 0, 3);
      tick();
      expect_eq("t6_pre_valid", DATA_W'(out_valid), DATA_W'(1));
      set_tag(0, 0, 1'b0); tick();
      clear_tags(); set_data(0, rnd_data());
      #2 rst = 1'b0;
      #1;
      expect_eq("t6_rst_valid", DATA_W'(out_valid),   DATA_W'(0));
      expect_eq("t6_rst_instr", DATA_W'(out_instr),   DATA_W'(0));
      expect_eq("t6_rst_ready", DATA_W'(alloc_ready), DATA_W'(1));
      #2 rst = 1'b1;
      tick();
      expect_eq("t6_stale_err",   DATA_W'(protocol_err), DATA_W'(0));
      expect_eq("t6_first_ocid",  DATA_W'(alloc_ocid),   DATA_W'(0));

      // Fill up with no-need entries while exec stalls, then drain.
      for (int i = 0; i < 9; i++) begin
         if (i != 2) sb.push_back(mk(ord[i], i % 8, 32'h4000 + i, '0, '0));
         do_alloc(i % 8, 32'h4000 + i, 1'b0, 1'b0, 0, 0, ord[i]);
      end
      sb.push_back(mk(0, 2, 32'h4002, '0, '0));
      expect_eq("t4_full", DATA_W'(alloc_ready), DATA_W'(0));
      alloc_valid = 1'b1; alloc_instr = 32'hdead_beef;
      tick();
      alloc_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      expect_eq("t4_ready_after_pop", DATA_W'(alloc_ready), DATA_W'(1));
      repeat (8) tick();
      expect_eq("t4_b2b_left", DATA_W'(sb.size()),  DATA_W'(0));
      expect_eq("t4_empty",    DATA_W'(out_valid),  DATA_W'(0));

      // Return tagged to a FREE entry.
      set_tag(1, 5, 1'b0); tick();
      clear_tags(); set_data(1, rnd_data()); tick();
      expect_eq("t5_err", DATA_W'(protocol_err), DATA_W'(1));
      repeat (3) tick();
      expect_eq("t5_sticky",  DATA_W'(protocol_err), DATA_W'(1));
      expect_eq("t5_no_disp", DATA_W'(out_valid),    DATA_W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
